// File: rtl/calc_sched_if.sv
// Signal bundle around calc_sched: requester handshake, datapath issue/return
// and the response/status outputs. The slave modport is the scheduler's view.
interface calc_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [N_REQ*DATA_WIDTH-1:0] req_a_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_b_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_c_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_d_i;
    logic [DATA_WIDTH-1:0]       dp_a_o;
    logic [DATA_WIDTH-1:0]       dp_b_o;
    logic [DATA_WIDTH-1:0]       dp_c_o;
    logic [DATA_WIDTH-1:0]       dp_d_o;
    logic                        dp_valid_o;
    logic [DATA_WIDTH-1:0]       dp_q_i;
    logic                        dp_q_valid_i;
    logic                        rsp_valid_o;
    logic [DATA_WIDTH-1:0]       rsp_data_o;
    logic [ID_W-1:0]             rsp_id_o;
    logic                        busy_o;
    logic                        err_unexp_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i,
        input  dp_q_i, dp_q_valid_i,
        output req_ready_o,
        output dp_a_o, dp_b_o, dp_c_o, dp_d_o, dp_valid_o,
        output rsp_valid_o, rsp_data_o, rsp_id_o,
        output busy_o, err_unexp_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i,
        output dp_q_i, dp_q_valid_i,
        input  req_ready_o,
        input  dp_a_o, dp_b_o, dp_c_o, dp_d_o, dp_valid_o,
        input  rsp_valid_o, rsp_data_o, rsp_id_o,
        input  busy_o, err_unexp_o
    );
endinterface

// File: rtl/calc_sched.sv
// calc_sched: round-robin scheduler sharing one q = ((a-b)*(1+3c)-4d)/2
// datapath between N_REQ requesters. Each issue records its owner in an
// in-order tag FIFO; each returned result is tagged with the FIFO head.
module calc_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int TAG_DEPTH  = 8,
    parameter int BLANK_CYC  = 8
) (
    input  logic        clk_i,
    input  logic        srst_i,
    calc_sched_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam int BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    // FIFO pointer advance with wrap at TAG_DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(TAG_DEPTH - 1)) begin
            r = PTR_W'(0);
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Requester index advance with wrap at N_REQ.
    function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] p);
        logic [ID_W-1:0] r;
        if (p == ID_W'(N_REQ - 1)) begin
            r = ID_W'(0);
        end else begin
            r = p + ID_W'(1);
        end
        return r;
    endfunction

    logic [BLK_W-1:0]      blank_cnt_r;
    logic [ID_W-1:0]       rr_ptr_r;
    logic [ID_W-1:0]       tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_next_s;

    logic                  blank_done_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  can_grant_s;
    logic                  grant_vld_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic [ID_W-1:0]       cand_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  unexp_s;
    logic [DATA_WIDTH-1:0] gnt_a_s;
    logic [DATA_WIDTH-1:0] gnt_b_s;
    logic [DATA_WIDTH-1:0] gnt_c_s;
    logic [DATA_WIDTH-1:0] gnt_d_s;

    logic                  dp_valid_r;
    logic [DATA_WIDTH-1:0] dp_a_r;
    logic [DATA_WIDTH-1:0] dp_b_r;
    logic [DATA_WIDTH-1:0] dp_c_r;
    logic [DATA_WIDTH-1:0] dp_d_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic [ID_W-1:0]       rsp_id_r;
    logic                  busy_r;
    logic                  err_unexp_r;

    // Results are ignored and grants withheld until the blanking window ends;
    // the full test looks at the count before any pop in the same cycle.
    assign blank_done_s = (blank_cnt_r == BLK_W'(0));
    assign fifo_full_s  = (count_r == CNT_W'(TAG_DEPTH));
    assign fifo_empty_s = (count_r == CNT_W'(0));
    assign can_grant_s  = blank_done_s && !fifo_full_s;
    assign push_s       = grant_vld_s;
    assign pop_s        = blank_done_s && bus.dp_q_valid_i && !fifo_empty_s;
    assign unexp_s      = blank_done_s && bus.dp_q_valid_i && fifo_empty_s;

    // Round-robin search starting at rr_ptr_r, first valid requester wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = rr_ptr_r;
        cand_s      = rr_ptr_r;
        if (can_grant_s) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_vld_s && bus.req_valid_i[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
                cand_s = id_inc(cand_s);
            end
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    assign bus.req_ready_o = grant_vld_s ? (N_REQ'(1) << grant_idx_s) : N_REQ'(0);

    // Operand mux for the granted requester's slice of the packed buses.
    always_comb begin
        gnt_a_s = bus.req_a_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        gnt_b_s = bus.req_b_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        gnt_c_s = bus.req_c_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        gnt_d_s = bus.req_d_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Post-reset blanking countdown.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            blank_cnt_r <= BLK_W'(BLANK_CYC);
        end else if (!blank_done_s) begin
            blank_cnt_r <= blank_cnt_r - BLK_W'(1);
        end else begin
            blank_cnt_r <= blank_cnt_r;
        end
    end

    // Round-robin pointer moves past the winner only when a grant happens.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rr_ptr_r <= ID_W'(0);
        end else if (grant_vld_s) begin
            rr_ptr_r <= id_inc(grant_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag FIFO: owner id pushed on grant, head popped on an accepted result.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= ID_W'(0);
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
        end
    end

    // Issue stage: operands registered the cycle after the grant, held otherwise.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            dp_valid_r <= 1'b0;
            dp_a_r     <= DATA_WIDTH'(0);
            dp_b_r     <= DATA_WIDTH'(0);
            dp_c_r     <= DATA_WIDTH'(0);
            dp_d_r     <= DATA_WIDTH'(0);
        end else if (grant_vld_s) begin
            dp_valid_r <= 1'b1;
            dp_a_r     <= gnt_a_s;
            dp_b_r     <= gnt_b_s;
            dp_c_r     <= gnt_c_s;
            dp_d_r     <= gnt_d_s;
        end else begin
            dp_valid_r <= 1'b0;
        end
    end

    // Return stage: a popped result goes out next cycle tagged with its owner.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= DATA_WIDTH'(0);
            rsp_id_r    <= ID_W'(0);
        end else if (pop_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus.dp_q_i;
            rsp_id_r    <= tag_mem_r[rd_ptr_r];
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Status: busy mirrors FIFO occupancy, unexpected-result flag is sticky.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            busy_r      <= 1'b0;
            err_unexp_r <= 1'b0;
        end else begin
            busy_r      <= (count_next_s != CNT_W'(0));
            err_unexp_r <= err_unexp_r | unexp_s;
        end
    end

    assign bus.dp_valid_o  = dp_valid_r;
    assign bus.dp_a_o      = dp_a_r;
    assign bus.dp_b_o      = dp_b_r;
    assign bus.dp_c_o      = dp_c_r;
    assign bus.dp_d_o      = dp_d_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_data_o  = rsp_data_r;
    assign bus.rsp_id_o    = rsp_id_r;
    assign bus.busy_o      = busy_r;
    assign bus.err_unexp_o = err_unexp_r;
endmodule
